// File: rtl/demo_scene_sequencer.sv
// ---------------------------------------------------------------------------
// demo_scene_sequencer
//
// Frame-locked scene scheduler for the demo top level. Each falling edge of
// v_sync is one frame "tick". The sequencer steps through NUM_SCENES scenes
// of SCENE_FRAMES frames each. For every scene it reports:
//   - the scene index and the frame number within the scene,
//   - a 2-bit fade level (fade-in at the start of a scene, fade-out at its end),
//   - an audio mute flag.
// Pause (level) and skip (rising edge) controls come from ui_in and are
// synchronised inside this block.
//
// Build option:
//   DEMO_SEQ_LOOP_EN  defined   -> the last scene wraps back to scene 0; done is
//                                  never asserted.
//                     undefined -> after the last frame of the last scene the
//                                  sequencer parks in DONE until reset.
//
// Ports:
//   clk          in   1        system (pixel) clock
//   rst_n        in   1        asynchronous reset, active-low
//   v_sync       in   1        VGA vertical sync, active-low, clk-synchronous
//   pause        in   1        asynchronous pause level
//   skip         in   1        asynchronous skip button (rising edge used)
//   scene        out  SCENE_W  current scene index
//   scene_frame  out  FRAME_W  frame number within the current scene
//   fade         out  2        brightness level, 0 = black .. 3 = full
//   scene_start  out  1        one-clock pulse on entry to a scene
//   audio_mute   out  1        1 = audio output forced silent
//   done         out  1        1 = sequence finished
// ---------------------------------------------------------------------------
module demo_scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 300,
  parameter int FADE_STEP    = 4,
  parameter int FRAME_W      = 9,
  localparam int SCENE_W     = ($clog2(NUM_SCENES) > 1) ? $clog2(NUM_SCENES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               v_sync,
  input  logic               pause,
  input  logic               skip,
  output logic [SCENE_W-1:0] scene,
  output logic [FRAME_W-1:0] scene_frame,
  output logic [1:0]         fade,
  output logic               scene_start,
  output logic               audio_mute,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(SCENE_FRAMES - 1);
  localparam logic [SCENE_W-1:0] LAST_SCENE = SCENE_W'(NUM_SCENES - 1);

  // Fade ramp: up over the first 4*FADE_STEP frames, down over the last
  // 4*FADE_STEP frames, full brightness in between.
  function automatic logic [1:0] fade_of(input logic [FRAME_W-1:0] f);
    int fi;
    int v;
    fi = 32'(f);
    if (fi < 4 * FADE_STEP)
      v = fi / FADE_STEP;
    else if (fi >= SCENE_FRAMES - 4 * FADE_STEP)
      v = (SCENE_FRAMES - 1 - fi) / FADE_STEP;
    else
      v = 3;
    return v[1:0];
  endfunction

  state_t               state_q, state_d;
  logic [SCENE_W-1:0]   scene_q, scene_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [1:0]           fade_q, fade_d;
  logic                 start_q, start_d;
  logic                 mute_q, mute_d;
  logic                 done_q, done_d;
  logic                 pending_q, pending_d;
  logic                 vsync_q, vsync_d;
  logic                 pause_s1_q, pause_s1_d;
  logic                 pause_s2_q, pause_s2_d;
  logic                 skip_s1_q, skip_s1_d;
  logic                 skip_s2_q, skip_s2_d;
  logic                 skip_s3_q, skip_s3_d;

  logic tick;
  logic skip_edge;
  logic advance;

  // Input conditioning: 2-FF synchronisers, skip edge detect, v_sync history.
  always_comb begin
    vsync_d    = v_sync;
    pause_s1_d = pause;
    pause_s2_d = pause_s1_q;
    skip_s1_d  = skip;
    skip_s2_d  = skip_s1_q;
    skip_s3_d  = skip_s2_q;
  end

  assign tick      = vsync_q & ~v_sync;
  assign skip_edge = skip_s2_q & ~skip_s3_q;

  // Sequencing: next state, scene/frame counters, fade and mute.
  always_comb begin
    state_d   = state_q;
    scene_d   = scene_q;
    frame_d   = frame_q;
    fade_d    = fade_q;
    start_d   = 1'b0;
    mute_d    = mute_q;
    done_d    = done_q;
    advance   = 1'b0;
    // An edge arriving on the tick clock is kept for the following frame.
    pending_d = skip_edge | (pending_q & ~tick);

    if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          scene_d = '0;
          frame_d = '0;
          start_d = 1'b1;
        end
        RUN: begin
          if (pause_s2_q)
            state_d = PAUSE;
          else if (pending_q || frame_q == LAST_FRAME)
            advance = 1'b1;
          else
            frame_d = frame_q + FRAME_W'(1);
        end
        PAUSE: begin
          // Leaving pause costs one held frame; a skip while paused still
          // moves to the next scene but remains paused.
          if (!pause_s2_q)
            state_d = RUN;
          else if (pending_q)
            advance = 1'b1;
        end
        default: ;
      endcase
    end

    if (advance) begin
      if (scene_q == LAST_SCENE) begin
`ifdef DEMO_SEQ_LOOP_EN
        scene_d = '0;
        frame_d = '0;
        start_d = 1'b1;
`else
        state_d = DONE;
        frame_d = LAST_FRAME;
        done_d  = 1'b1;
`endif
      end else begin
        scene_d = scene_q + SCENE_W'(1);
        frame_d = '0;
        start_d = 1'b1;
      end
    end

    if (tick && state_q != DONE) begin
      fade_d = (state_d == DONE) ? 2'd0 : fade_of(frame_d);
      mute_d = (state_d != RUN) | (fade_d == 2'd0);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scene_q    <= '0;
      frame_q    <= '0;
      fade_q     <= 2'd0;
      start_q    <= 1'b0;
      mute_q     <= 1'b1;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
      vsync_q    <= 1'b1;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
      skip_s1_q  <= 1'b0;
      skip_s2_q  <= 1'b0;
      skip_s3_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      scene_q    <= scene_d;
      frame_q    <= frame_d;
      fade_q     <= fade_d;
      start_q    <= start_d;
      mute_q     <= mute_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      vsync_q    <= vsync_d;
      pause_s1_q <= pause_s1_d;
      pause_s2_q <= pause_s2_d;
      skip_s1_q  <= skip_s1_d;
      skip_s2_q  <= skip_s2_d;
      skip_s3_q  <= skip_s3_d;
    end
  end

  assign scene       = scene_q;
  assign scene_frame = frame_q;
  assign fade        = fade_q;
  assign scene_start = start_q;
  assign audio_mute  = mute_q;
  assign done        = done_q;

endmodule
